// File: rtl/rms_accum_if.sv
// Sample stream into the mean-square accumulator and its held result toward the sqrt pipeline.
// The master drives samples; the slave (rms_accum) returns the window mean and its strobes.
interface rms_accum_if #(
    parameter int G_SAMPLE_W = 4,
    parameter int G_WIDTH    = 8
);
    logic signed [G_SAMPLE_W-1:0] sample;
    logic                         sample_valid;
    logic                         clear;
    logic        [G_WIDTH-1:0]    mean_sq;
    logic                         ms_valid;
    logic                         rms_valid;

    modport master (
        output sample,
        output sample_valid,
        output clear,
        input  mean_sq,
        input  ms_valid,
        input  rms_valid
    );

    modport slave (
        input  sample,
        input  sample_valid,
        input  clear,
        output mean_sq,
        output ms_valid,
        output rms_valid
    );
endinterface

// File: rtl/rms_accum.sv
// Squares signed samples, averages them over a 2^G_LOG_N-sample window and holds the mean square
// for a free-running sqrt; rms_valid marks when the sqrt output reflects a fresh window.
module rms_accum #(
    parameter int G_SAMPLE_W = 4,
    parameter int G_LOG_N    = 4,
    parameter int G_WIDTH    = 8,
    parameter int G_SQRT_LAT = 4
) (
    input logic        clk,
    input logic        rst_n,
    rms_accum_if.slave bus
);
    localparam int SQ_W  = 2 * G_SAMPLE_W;
    localparam int ACC_W = SQ_W + G_LOG_N;

    logic        [SQ_W-1:0]       sq_q, sq_d;
    logic                         sq_valid_q, sq_valid_d;
    logic        [ACC_W-1:0]      acc_q, acc_d;
    logic        [G_LOG_N-1:0]    cnt_q, cnt_d;
    logic        [G_WIDTH-1:0]    mean_sq_q, mean_sq_d;
    logic                         ms_valid_q, ms_valid_d;
    logic        [G_SQRT_LAT-1:0] dl_q, dl_d;

    logic signed [SQ_W-1:0]       sample_ext;
    logic signed [SQ_W-1:0]       sq_prod;
    logic        [ACC_W-1:0]      total;
    logic        [SQ_W-1:0]       shifted;
    logic        [G_WIDTH-1:0]    mean_next;

    // Squaring at double width keeps the most negative sample exact.
    assign sample_ext = SQ_W'(bus.sample);
    assign sq_prod    = sample_ext * sample_ext;

    assign total   = acc_q + ACC_W'(sq_q);
    assign shifted = SQ_W'(total >> G_LOG_N);

    generate
        if (SQ_W > G_WIDTH) begin : g_sat
            assign mean_next = (|shifted[SQ_W-1:G_WIDTH]) ? {G_WIDTH{1'b1}}
                                                          : shifted[G_WIDTH-1:0];
        end else begin : g_nosat
            assign mean_next = G_WIDTH'(shifted);
        end
    endgenerate

    always_comb begin
        sq_d       = sq_q;
        sq_valid_d = 1'b0;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mean_sq_d  = mean_sq_q;
        ms_valid_d = 1'b0;
        if (bus.clear) begin
            // Abort: partial sum and in-flight square are dropped, held mean stays.
            acc_d = '0;
            cnt_d = '0;
        end else begin
            if (bus.sample_valid) begin
                sq_d       = unsigned'(sq_prod);
                sq_valid_d = 1'b1;
            end
            if (sq_valid_q) begin
                if (&cnt_q) begin
                    mean_sq_d  = mean_next;
                    ms_valid_d = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                end else begin
                    acc_d = total;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Valid delay line matching the sqrt latency; clear flushes every stage.
    assign dl_d[0] = bus.clear ? 1'b0 : ms_valid_q;
    generate
        for (genvar gi = 1; gi < G_SQRT_LAT; gi++) begin : g_dl
            assign dl_d[gi] = bus.clear ? 1'b0 : dl_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_q       <= '0;
            sq_valid_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mean_sq_q  <= '0;
            ms_valid_q <= 1'b0;
            dl_q       <= '0;
        end else begin
            sq_q       <= sq_d;
            sq_valid_q <= sq_valid_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mean_sq_q  <= mean_sq_d;
            ms_valid_q <= ms_valid_d;
            dl_q       <= dl_d;
        end
    end

    assign bus.mean_sq   = mean_sq_q;
    assign bus.ms_valid  = ms_valid_q;
    assign bus.rms_valid = dl_q[G_SQRT_LAT-1];
endmodule

// File: tb/tb_rms_accum.sv
// Bench for rms_accum: table of constant windows plus hand-written gap, clear, reset and
// saturation sequences; expected means and strobe cycles go through a scoreboard queue.
module tb_rms_accum;
    localparam int SW   = 4;
    localparam int LOGN = 4;
    localparam int W    = 8;
    localparam int LAT  = 4;
    localparam int W2   = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rms_accum_if #(.G_SAMPLE_W(SW), .G_WIDTH(W))  bus ();
    rms_accum_if #(.G_SAMPLE_W(SW), .G_WIDTH(W2)) bus2 ();

    rms_accum #(.G_SAMPLE_W(SW), .G_LOG_N(LOGN), .G_WIDTH(W), .G_SQRT_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    rms_accum #(.G_SAMPLE_W(SW), .G_LOG_N(LOGN), .G_WIDTH(W2), .G_SQRT_LAT(LAT)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct { int mean; int cyc; } exp_t;
    typedef struct { int val; int exp_mean; } vec_t;

    exp_t sb[$];
    int   rms_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: every ms_valid pops an expected mean/cycle, every rms_valid a cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.ms_valid) begin
                if (sb.size() == 0) check("unexpected_ms_valid", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("mean_sq", 32'(bus.mean_sq), e.mean);
                    check("ms_valid_cycle", cyc, e.cyc);
                    rms_q.push_back(e.cyc + LAT);
                end
            end
            if (bus.rms_valid) begin
                if (rms_q.size() == 0) check("unexpected_rms_valid", 1, 0);
                else check("rms_valid_cycle", cyc, rms_q.pop_front());
            end
        end
    end

    task automatic drive(input int val, input bit v, input bit clr);
        @(negedge clk);
        bus.sample       = SW'(val);
        bus.sample_valid = v;
        bus.clear        = clr;
        $display("drive  cyc=%0d sample=%0d valid=%0d clear=%0d", cyc, val, v, clr);
    endtask

    task automatic drive2(input int val, input bit v);
        @(negedge clk);
        bus2.sample       = SW'(val);
        bus2.sample_valid = v;
        bus2.clear        = 1'b0;
        $display("drive2 cyc=%0d sample=%0d valid=%0d", cyc, val, v);
    endtask

    task automatic push_exp(input int mean);
        exp_t e;
        e.mean = mean;
        e.cyc  = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic window(input int val, input int exp_mean);
        for (int i = 0; i < 16; i++) drive(val, 1'b1, 1'b0);
        push_exp(exp_mean);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || rms_q.size() != 0) && k < 40) begin
            drive(0, 1'b0, 1'b0);
            k++;
        end
        drive(0, 1'b0, 1'b0);
        check("drain_pending", sb.size() + rms_q.size(), 0);
    endtask

    task automatic wait_ms_valid();
        int k;
        k = 0;
        while (!bus.ms_valid && k < 40) begin
            drive(0, 1'b0, 1'b0);
            k++;
        end
        check("ms_valid_seen", 32'(bus.ms_valid), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mean_sq"}, 32'(bus.mean_sq), 0);
        check({tag, "_ms_valid"}, 32'(bus.ms_valid), 0);
        check({tag, "_rms_valid"}, 32'(bus.rms_valid), 0);
    endtask

    initial begin
        vec_t tbl[8];
        int   seq[16];
        int   k;
        int   exp_cyc;

        tbl[0] = '{3, 9};   tbl[1] = '{-8, 64}; tbl[2] = '{1, 1};  tbl[3] = '{-7, 49};
        tbl[4] = '{4, 16};  tbl[5] = '{7, 49};  tbl[6] = '{0, 0};  tbl[7] = '{-1, 1};
        seq = '{0, -1, 2, -3, 4, -5, 6, -7, 7, -6, 5, -4, 3, -2, 1, 0};

        bus.sample = '0;  bus.sample_valid = 1'b0;  bus.clear = 1'b0;
        bus2.sample = '0; bus2.sample_valid = 1'b0; bus2.clear = 1'b0;

        #1 rst_n = 1'b0;
        #3 check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back constant windows; pulses must land exactly 16 cycles apart.
        for (int i = 0; i < 8; i++) window(tbl[i].val, tbl[i].exp_mean);
        drain();
        repeat (5) drive(0, 1'b0, 1'b0);
        check("mean_sq_hold", 32'(bus.mean_sq), 1);

        // Alternating-sign ramp with random gaps carrying junk on the sample bus.
        for (int i = 0; i < 16; i++) begin
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) drive(int'($urandom_range(0, 15)) - 8, 1'b0, 1'b0);
            drive(seq[i], 1'b1, 1'b0);
        end
        push_exp(17);
        drain();

        // Partial window aborted by clear; the sample presented with clear is dropped.
        for (int i = 0; i < 10; i++) drive(5, 1'b1, 1'b0);
        drive(5, 1'b1, 1'b1);
        drive(0, 1'b0, 1'b0);
        check("clear_hold_mean_sq", 32'(bus.mean_sq), 17);
        check("clear_ms_valid", 32'(bus.ms_valid), 0);
        window(2, 4);
        drain();

        // Asynchronous reset mid-window.
        for (int i = 0; i < 5; i++) drive(4, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset_mid_window");
        sb.delete();
        rms_q.delete();
        drive(0, 1'b0, 1'b0);
        rst_n = 1'b1;
        window(4, 16);
        wait_ms_valid();

        // Reset between ms_valid and rms_valid: the pending rms_valid must never appear.
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset_before_rms");
        sb.delete();
        rms_q.delete();
        drive(0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (10) drive(0, 1'b0, 1'b0);
        window(4, 16);
        drain();

        // Narrow output instance: 1024 >> 4 = 64 saturates to 63.
        for (int i = 0; i < 16; i++) drive2(-8, 1'b1);
        exp_cyc = cyc + 2;
        k = 0;
        while (!bus2.ms_valid && k < 40) begin
            drive2(0, 1'b0);
            k++;
        end
        check("sat_ms_valid_seen", 32'(bus2.ms_valid), 1);
        check("sat_ms_valid_cycle", cyc, exp_cyc);
        check("sat_mean_sq", 32'(bus2.mean_sq), 63);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, required completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
